uart_tx_sequencer: RTL and testbench
====================================

# uart_tx_sequencer

Transmit-side controller for the serial peripheral: drains 9-bit entries from the 16-deep transmit FIFO and serializes each entry onto `tx` as an asynchronous UART frame. Bit 8 of each FIFO entry selects a break frame. The block issues one FIFO read per frame, confirms the read by watching the FIFO read index, and sequences start, data, parity and stop bits at a programmable bit period. It sits between the AXI-written TX FIFO and the pad.

## Interface
- `DIV_WIDTH`, 16, width of bit-period divisor
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  reset, synchronous, active-low
- `enable`  in  1  transmitter enable
- `brd`  in  DIV_WIDTH  clocks per bit; values 0 and 1 treated as 2
- `data_bits`  in  2  00=5, 01=6, 10=7, 11=8 data bits
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 stick-1 (mark)
- `two_stop`  in  1  1 = two stop bits, 0 = one
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd_index`  in  5  FIFO read pointer (incl. wrap bit)
- `fifo_rd_data`  in  9  FIFO registered read data
- `fifo_rd_request`  out  1  one-cycle read strobe to FIFO
- `tx`  out  1  serial output, idle high
- `busy`  out  1  high in any state other than IDLE
- `frame_done`  out  1  one-cycle pulse at end of last stop bit

## Operation
- States: IDLE, REQ, CHECK, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If `enable` && !`fifo_empty`: latch `fifo_rd_index` into `idx_q`, go to REQ.
- REQ: `fifo_rd_request`=1 for exactly this cycle; go to CHECK.
- CHECK: `fifo_rd_request`=0.
  - If `fifo_rd_index` != `idx_q`, the read completed. Capture `fifo_rd_data`. Latch `brd`, `data_bits`, `parity_mode` and `two_stop` into shadow registers. Go to START.
  - Otherwise the read was blocked by a concurrent FIFO write or clear. Return to REQ; retries are unbounded.
- START: `tx`=0 for one bit period.
- DATA: LSB first, bits 0..N-1, where N = 5 + `data_bits`; one bit period each.
- PARITY: entered only if the shadow parity mode is non-zero. Parity value:
  - even: XOR of the N data bits;
  - odd: inverted XOR;
  - stick: 1.
- STOP: `tx`=1 for 1 or 2 bit periods. At the last clock of the final stop bit, pulse `frame_done`. Next state:
  - REQ directly (latching `idx_q`) if `enable` && !`fifo_empty`;
  - otherwise IDLE.
- Break frame (captured bit 8 = 1): `tx`=0 through the START, DATA and PARITY slots, ignoring data. STOP is normal (high).
- Shadow configuration is fixed for the whole frame. Register writes mid-frame take effect from the next frame.
- Deasserting `enable` mid-frame does not abort: the current frame completes, then the block goes to IDLE. If `enable` drops in REQ or CHECK, the fetch still completes and the frame is sent.
- Bit counter: counts 0..brd_eff-1 per bit, brd_eff = max(`brd`,2). A bit ends when the counter equals brd_eff-1.

## Timing
- All outputs registered except `busy`, which is decoded from a registered state.
- Reset values: `tx`=1, `fifo_rd_request`=0, `busy`=0, `frame_done`=0, state=IDLE, counters 0.
- Reset mid-frame: at the next edge `tx`=1 and state=IDLE. No FIFO read is issued while `reset`=0.
- Latency (T0 = IDLE cycle with `enable` && !`fifo_empty`):
  - `fifo_rd_request` high in T1;
  - index change seen in T2;
  - `tx` falls in T3.
- Frame length = (1 + N + P + S) × brd_eff clocks, with P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames: 2 clocks of idle-high (REQ, CHECK) between the last stop bit and the next start bit.
- Index compare uses all 5 bits, so the wrap 31→0 counts as a change.
- At most one `fifo_rd_request` pulse per frame, never two in consecutive cycles.

## Test plan
- 8N1, brd=4, FIFO holds 0x055:
  - `tx` = 0,1,0,1,0,1,0,1,0,1, each level 4 clocks;
  - `frame_done` pulse at clock 40 after `tx` falls;
  - exactly one read.
- 7 data bits, even parity, two stop, brd=3, data 0x041: data bits LSB first 1,0,0,0,0,0,1, parity=0, then 6 high clocks; total 33 clocks.
- FIFO write asserted in the same cycle as `fifo_rd_request` (index unchanged at CHECK) → second `fifo_rd_request` 1 clock later; correct byte transmitted once.
- Entry 0x1xx (bit 8 set), 8N1, brd=2 → `tx` low 18 clocks, high 2, `frame_done` pulse, no data pattern.
- Three entries queued, enable held: three frames, each separated by exactly 2 idle-high clocks. FIFO empty afterwards → IDLE, `busy`=0.
- `reset`=0 during DATA bit 3 → next edge `tx`=1, `busy`=0. After release with FIFO non-empty, a new frame starts with T1 request timing.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART transmit sequencer draining the TX FIFO onto the serial pad
module uart_tx_sequencer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] brd,
  input  logic [1:0]           data_bits,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 fifo_empty,
  input  logic [4:0]           fifo_rd_index,
  input  logic [8:0]           fifo_rd_data,
  output logic                 fifo_rd_request,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_CHECK, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t state, nxt_state;

  logic [DIV_WIDTH-1:0] cnt, nxt_cnt, brd_q, brd_eff, bit_last;
  logic [2:0]           bit_idx, nxt_bit_idx;
  logic [4:0]           idx_q;
  logic [7:0]           data_q, data_mask;
  logic                 brk_q;
  logic [1:0]           data_bits_q, parity_q;
  logic                 two_stop_q;
  logic                 fetch, bit_end, last_data, last_stop, par_bit;
  logic                 latch_idx, capture;
  logic                 tx_d, req_d, done_d;

  assign brd_eff   = (brd < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : brd;
  assign bit_last  = brd_q - DIV_WIDTH'(1);
  assign bit_end   = (cnt == bit_last);
  assign last_data = (bit_idx == 3'd4 + {1'b0, data_bits_q});
  assign last_stop = (bit_idx == {2'b00, two_stop_q});
  assign fetch     = enable && !fifo_empty;
  assign data_mask = 8'hff >> (2'd3 - data_bits);
  assign busy      = (state != S_IDLE);

  // Data is masked to N bits at capture, so parity can fold the whole byte.
  always_comb begin
    case (parity_q)
      2'b01:   par_bit = ^data_q;
      2'b10:   par_bit = ~^data_q;
      default: par_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      idx_q           <= '0;
      data_q          <= '0;
      brk_q           <= 1'b0;
      brd_q           <= '0;
      data_bits_q     <= '0;
      parity_q        <= '0;
      two_stop_q      <= 1'b0;
      tx              <= 1'b1;
      fifo_rd_request <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      state           <= nxt_state;
      cnt             <= nxt_cnt;
      bit_idx         <= nxt_bit_idx;
      tx              <= tx_d;
      fifo_rd_request <= req_d;
      frame_done      <= done_d;
      if (latch_idx) idx_q <= fifo_rd_index;
      if (capture) begin
        data_q      <= fifo_rd_data[7:0] & data_mask;
        brk_q       <= fifo_rd_data[8];
        brd_q       <= brd_eff;
        data_bits_q <= data_bits;
        parity_q    <= parity_mode;
        two_stop_q  <= two_stop;
      end
    end
  end

  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_bit_idx = bit_idx;
    latch_idx   = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE: begin
        nxt_cnt     = '0;
        nxt_bit_idx = '0;
        if (fetch) begin
          nxt_state = S_REQ;
          latch_idx = 1'b1;
        end
      end
      S_REQ: nxt_state = S_CHECK;
      S_CHECK: begin
        nxt_cnt     = '0;
        nxt_bit_idx = '0;
        // An unchanged index means a concurrent write/clear swallowed the read.
        if (fifo_rd_index != idx_q) begin
          nxt_state = S_START;
          capture   = 1'b1;
        end else begin
          nxt_state = S_REQ;
        end
      end
      S_START, S_DATA, S_PARITY, S_STOP: begin
        if (!bit_end) begin
          nxt_cnt = cnt + DIV_WIDTH'(1);
        end else begin
          nxt_cnt = '0;
          case (state)
            S_START: begin
              nxt_state   = S_DATA;
              nxt_bit_idx = '0;
            end
            S_DATA: begin
              if (!last_data) begin
                nxt_bit_idx = bit_idx + 3'd1;
              end else begin
                nxt_bit_idx = '0;
                nxt_state   = (parity_q != 2'b00) ? S_PARITY : S_STOP;
              end
            end
            S_PARITY: begin
              nxt_state   = S_STOP;
              nxt_bit_idx = '0;
            end
            default: begin
              if (!last_stop) begin
                nxt_bit_idx = bit_idx + 3'd1;
              end else begin
                nxt_bit_idx = '0;
                if (fetch) begin
                  nxt_state = S_REQ;
                  latch_idx = 1'b1;
                end else begin
                  nxt_state = S_IDLE;
                end
              end
            end
          endcase
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the upcoming state so they align with it.
  always_comb begin
    tx_d   = 1'b1;
    req_d  = (nxt_state == S_REQ);
    done_d = (nxt_state == S_STOP) && (nxt_cnt == bit_last) &&
             (nxt_bit_idx == {2'b00, two_stop_q});
    case (nxt_state)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = brk_q ? 1'b0 : data_q[nxt_bit_idx];
      S_PARITY: tx_d = brk_q ? 1'b0 : par_bit;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - directed bench for uart_tx_sequencer with a small FIFO model
module tb_uart_tx_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] brd;
  logic [1:0]  data_bits;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        fifo_empty;
  logic [4:0]  fifo_rd_index;
  logic [8:0]  fifo_rd_data;
  logic        fifo_rd_request;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  uart_tx_sequencer #(.DIV_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .brd(brd),
    .data_bits(data_bits), .parity_mode(parity_mode), .two_stop(two_stop),
    .fifo_empty(fifo_empty), .fifo_rd_index(fifo_rd_index),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_request(fifo_rd_request),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: pointers start at 30 so the read index wraps 31->0 early on.
  logic [8:0] mem [0:15];
  logic [4:0] wr_ptr = 5'd30;
  logic [4:0] rd_ptr = 5'd30;
  int         req_count = 0;
  int         block_at = -1;

  assign fifo_rd_index = rd_ptr;
  assign fifo_empty    = (wr_ptr == rd_ptr);

  always @(negedge clk) begin
    if (fifo_rd_request) begin
      req_count = req_count + 1;
      if (req_count != block_at && wr_ptr != rd_ptr) begin
        fifo_rd_data = mem[rd_ptr[3:0]];
        rd_ptr       = rd_ptr + 5'd1;
      end
    end
  end

  task automatic push(input logic [8:0] v);
    mem[wr_ptr[3:0]] = v;
    wr_ptr = wr_ptr + 5'd1;
  endtask

  logic exp_tx [0:255];
  logic exp_done [0:255];
  logic tx_log [0:255];
  logic done_log [0:255];

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) begin
      exp_tx[i]   = 1'b1;
      exp_done[i] = 1'b0;
    end
  endtask

  task automatic add_frame(input logic [8:0] e, input int nbits, input int pmode,
                           input int nstop, input int be, inout int pos);
    logic lv [0:11];
    logic p;
    int   nb;
    nb = 0;
    p  = 1'b0;
    lv[nb] = 1'b0; nb++;
    for (int i = 0; i < nbits; i++) begin
      lv[nb] = e[8] ? 1'b0 : e[i]; nb++;
      p = p ^ e[i];
    end
    if (pmode != 0) begin
      lv[nb] = e[8] ? 1'b0 : (pmode == 1) ? p : (pmode == 2) ? ~p : 1'b1; nb++;
    end
    for (int i = 0; i < nstop; i++) begin
      lv[nb] = 1'b1; nb++;
    end
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < be; c++) begin
        exp_tx[pos] = lv[b];
        pos++;
      end
    exp_done[pos-1] = 1'b1;
  endtask

  task automatic capture(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      tx_log[start+i]   = tx;
      done_log[start+i] = frame_done;
      @(negedge clk);
    end
  endtask

  function automatic int first_diff(input int n);
    for (int i = 0; i < n; i++)
      if (tx_log[i] !== exp_tx[i] || done_log[i] !== exp_done[i]) return i;
    return -1;
  endfunction

  task automatic wait_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; brd = 16'd4; data_bits = 2'b11;
    parity_mode = 2'b00; two_stop = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_rd_request !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", fifo_rd_request); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_8n1();
    int r0, pos, d;
    bit ok;
    brd = 16'd4; data_bits = 2'b11; parity_mode = 2'b00; two_stop = 1'b0; enable = 1'b1;
    r0 = req_count;
    @(posedge clk); #2; push(9'h055);
    @(negedge clk);
    checks++; if (fifo_rd_request !== 1'b0) begin errors++; $display("FAIL t0_req: got %b want 0", fifo_rd_request); end
    @(negedge clk);
    checks++; if (fifo_rd_request !== 1'b1) begin errors++; $display("FAIL t1_req: got %b want 1", fifo_rd_request); end
    @(negedge clk);
    checks++; if (fifo_rd_request !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL t2_state: req=%b tx=%b want req=0 tx=1", fifo_rd_request, tx); end
    @(negedge clk);
    capture(0, 44);
    clear_exp(); pos = 0; add_frame(9'h055, 8, 0, 1, 4, pos);
    d = first_diff(44);
    checks++; if (d != -1) begin errors++; $display("FAIL frame_8n1 at clock %0d: tx=%b done=%b want tx=%b done=%b", d, tx_log[d], done_log[d], exp_tx[d], exp_done[d]); end
    checks++; if (req_count - r0 != 1) begin errors++; $display("FAIL reads_8n1: got %0d want 1", req_count - r0); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL idle_8n1: busy=%b want 0", busy); end
  endtask

  task automatic test_7e2_shadow();
    int pos, d;
    bit ok;
    brd = 16'd3; data_bits = 2'b10; parity_mode = 2'b01; two_stop = 1'b1; enable = 1'b1;
    @(posedge clk); #2; push(9'h041);
    @(negedge clk);
    wait_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL start_7e2: tx=%b want 0 within bound", tx); end
    capture(0, 10);
    // Mid-frame register changes must not disturb the frame in flight.
    brd = 16'd7; data_bits = 2'b00; parity_mode = 2'b10; two_stop = 1'b0;
    capture(10, 26);
    clear_exp(); pos = 0; add_frame(9'h041, 7, 1, 2, 3, pos);
    d = first_diff(36);
    checks++; if (d != -1) begin errors++; $display("FAIL frame_7e2 at clock %0d: tx=%b done=%b want tx=%b done=%b", d, tx_log[d], done_log[d], exp_tx[d], exp_done[d]); end
    checks++; if (pos != 33) begin errors++; $display("FAIL len_7e2: got %0d want 33", pos); end
    wait_idle(ok);
  endtask

  task automatic test_collision();
    int r0, pos, d;
    bit ok;
    brd = 16'd2; data_bits = 2'b11; parity_mode = 2'b00; two_stop = 1'b0; enable = 1'b1;
    r0 = req_count;
    block_at = req_count + 1;
    @(posedge clk); #2; push(9'h0A5);
    @(negedge clk);
    @(negedge clk);
    checks++; if (fifo_rd_request !== 1'b1) begin errors++; $display("FAIL col_req1: got %b want 1", fifo_rd_request); end
    @(negedge clk);
    checks++; if (fifo_rd_request !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL col_check: req=%b tx=%b want 0 1", fifo_rd_request, tx); end
    @(negedge clk);
    checks++; if (fifo_rd_request !== 1'b1) begin errors++; $display("FAIL col_req2: got %b want 1", fifo_rd_request); end
    @(negedge clk);
    checks++; if (fifo_rd_request !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL col_check2: req=%b tx=%b want 0 1", fifo_rd_request, tx); end
    @(negedge clk);
    capture(0, 26);
    clear_exp(); pos = 0; add_frame(9'h0A5, 8, 0, 1, 2, pos);
    d = first_diff(26);
    checks++; if (d != -1) begin errors++; $display("FAIL frame_col at clock %0d: tx=%b done=%b want tx=%b done=%b", d, tx_log[d], done_log[d], exp_tx[d], exp_done[d]); end
    checks++; if (req_count - r0 != 2 || rd_ptr !== wr_ptr) begin errors++; $display("FAIL reads_col: req=%0d empty=%b want 2 1", req_count - r0, fifo_empty); end
    block_at = -1;
    wait_idle(ok);
  endtask

  task automatic test_break();
    int pos, d;
    bit ok;
    brd = 16'd0; data_bits = 2'b11; parity_mode = 2'b00; two_stop = 1'b0; enable = 1'b1;
    @(posedge clk); #2; push(9'h1A5);
    @(negedge clk);
    wait_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL start_brk: tx=%b want 0 within bound", tx); end
    capture(0, 24);
    clear_exp(); pos = 0; add_frame(9'h1A5, 8, 0, 1, 2, pos);
    d = first_diff(24);
    checks++; if (d != -1) begin errors++; $display("FAIL frame_brk at clock %0d: tx=%b done=%b want tx=%b done=%b", d, tx_log[d], done_log[d], exp_tx[d], exp_done[d]); end
    checks++; if (tx_log[17] !== 1'b0 || tx_log[18] !== 1'b1) begin errors++; $display("FAIL brk_edge: clk17=%b clk18=%b want 0 1", tx_log[17], tx_log[18]); end
    wait_idle(ok);
  endtask

  task automatic test_back_to_back();
    int r0, pos, d;
    bit ok;
    enable = 1'b0; brd = 16'd1; data_bits = 2'b11; parity_mode = 2'b00; two_stop = 1'b0;
    r0 = req_count;
    @(posedge clk); #2;
    push(9'h0F0); push(9'h00F); push(9'h133);
    @(posedge clk); #2; enable = 1'b1;
    @(negedge clk);
    wait_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL start_b2b: tx=%b want 0 within bound", tx); end
    capture(0, 70);
    clear_exp(); pos = 0;
    add_frame(9'h0F0, 8, 0, 1, 2, pos); pos += 2;
    add_frame(9'h00F, 8, 0, 1, 2, pos); pos += 2;
    add_frame(9'h133, 8, 0, 1, 2, pos);
    d = first_diff(70);
    checks++; if (d != -1) begin errors++; $display("FAIL frame_b2b at clock %0d: tx=%b done=%b want tx=%b done=%b", d, tx_log[d], done_log[d], exp_tx[d], exp_done[d]); end
    wait_idle(ok);
    checks++; if (!ok || busy !== 1'b0) begin errors++; $display("FAIL idle_b2b: busy=%b want 0", busy); end
    checks++; if (req_count - r0 != 3) begin errors++; $display("FAIL reads_b2b: got %0d want 3", req_count - r0); end
  endtask

  task automatic test_reset_mid();
    int r0, pos, d;
    bit ok, seen_req;
    brd = 16'd4; data_bits = 2'b11; parity_mode = 2'b00; two_stop = 1'b0; enable = 1'b1;
    @(posedge clk); #2; push(9'h0C3); push(9'h03C);
    @(negedge clk);
    wait_fall(ok);
    checks++; if (!ok) begin errors++; $display("FAIL start_rst: tx=%b want 0 within bound", tx); end
    repeat (17) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid: tx=%b busy=%b want 1 0", tx, busy); end
    r0 = req_count;
    seen_req = 1'b0;
    repeat (3) begin
      if (fifo_rd_request !== 1'b0) seen_req = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen_req || req_count != r0) begin errors++; $display("FAIL rst_noread: req seen=%b reads=%0d want 0 0", seen_req, req_count - r0); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (fifo_rd_request !== 1'b1) begin errors++; $display("FAIL rst_t1_req: got %b want 1", fifo_rd_request); end
    @(negedge clk);
    @(negedge clk);
    capture(0, 44);
    clear_exp(); pos = 0; add_frame(9'h03C, 8, 0, 1, 4, pos);
    d = first_diff(44);
    checks++; if (d != -1) begin errors++; $display("FAIL frame_rst at clock %0d: tx=%b done=%b want tx=%b done=%b", d, tx_log[d], done_log[d], exp_tx[d], exp_done[d]); end
    wait_idle(ok);
    checks++; if (!ok || rd_ptr !== wr_ptr) begin errors++; $display("FAIL idle_rst: busy=%b empty=%b want 0 1", busy, fifo_empty); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    fifo_rd_data = 9'h000;
    test_reset();
    test_8n1();
    test_7e2_shadow();
    test_collision();
    test_break();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
